alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator side of the 8-bit ALU interface: accepts instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives ctrl/x/y to the external combinational ALU, captures {carry, out}, and writes the result back.
- Owns the architectural register file and the carry flag. Sits between the instruction source (testbench or future sequencer) and the ALU.

Parameters:
- DW, 8, datapath width; must equal the ALU width.
- NREG, 8, number of registers; register address width AW = clog2(NREG) = 3.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  controller can accept; high only in IDLE.
- in_op  input  4  operation code; 0000–1100 are ALU ops, 1111 is LOADI, 1101/1110 are reserved.
- in_rd  input  AW  destination register.
- in_rs1  input  AW  source register driven onto ALU x.
- in_rs2  input  AW  source register driven onto ALU y.
- in_imm  input  DW  immediate; used by LOADI only.
- alu_ctrl  output  4  to ALU ctrl.
- alu_x  output  DW  to ALU x.
- alu_y  output  DW  to ALU y.
- alu_out  input  DW  from ALU out.
- alu_carry  input  1  from ALU carry.
- done  output  1  one-cycle pulse on writeback.
- done_data  output  DW  value written in the done cycle.
- carry_flag  output  1  architectural carry flag.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  DW  combinational read of reg[dbg_addr]; shows the pre-write value during a WB cycle.

Behaviour:
- **Reset.** State=IDLE; all registers, carry_flag, alu_ctrl/x/y, done and done_data are 0; in_ready=1 on the first cycle after reset. Reset asserted in any state aborts the in-flight instruction with no writeback and no done pulse.
- **States and transitions.**
  - IDLE: in_ready=1. On in_valid&in_ready (cycle N), register op, rd, imm, reg[rs1]→alu_x, reg[rs2]→alu_y, op→alu_ctrl; go to EXEC.
  - EXEC (N+1): in_ready=0; alu_* outputs stable. At the end of the cycle, sample alu_out/alu_carry (or imm for LOADI) into the result register; go to WB.
  - WB (N+2): reg[rd] ← result; done=1; done_data=result; go to IDLE.
- **Throughput and latency.**
  - Throughput is one instruction per 3 cycles.
  - Latency from handshake to done is 2 cycles.
  - A new instruction may be accepted in the cycle after WB.
- **Operand capture.** Operands are read at accept time. rs1==rd or rs2==rd behaves correctly because the write happens in WB.
- **Back-to-back dependency.** No hazard exists: the next accept is at or after N+3, so it reads the written value.
- **carry_flag.** Updated in WB only for op 0000 (ADD) and 0001 (SUB), with the captured alu_carry. All other ops leave it unchanged.
- **Result width.** The result is the low DW bits of the ALU output; for op 1100 the result is 8'h01 (equal) or 8'h00.
- **Reserved ops 1101/1110.** Passed to the ALU. The result is 0 and is written to rd; carry_flag is unchanged.
- **LOADI (1111).**
  - Result = in_imm; ALU output is ignored.
  - alu_ctrl is still driven 1111 and alu_x/alu_y carry the operand reads (don't-care).
  - carry_flag is unchanged.
- **Handshake while not in IDLE.** in_valid is ignored; the source must hold the instruction until in_ready.
- **alu_* holding.** alu_* outputs hold their last values in IDLE/WB; there is no toggle on idle.

Decomposition:
- Shared package alu_pkg:
  - op-code constants OP_ADD…OP_EQ (0000–1100) and OP_LOADI=1111;
  - FSM state enum {IDLE, EXEC, WB};
  - DW/AW constants.
- One natural sub-module, alu_regfile:
  - NREG×DW, synchronous write, two combinational read ports plus a debug read port, reset-to-zero.

Test Plan:
- Reset, then LOADI r1=8'hF0 and LOADI r2=8'h20, then ADD r3=r1+r2:
  - first done 2 cycles after its handshake;
  - ADD done_data=8'h10, carry_flag=1;
  - dbg_addr=3 reads 8'h10.
- SUB r4=r2−r1 (0x20−0xF0):
  - alu_ctrl=0001 during EXEC;
  - r4=8'h30; carry_flag = ALU borrow bit (1).
- With carry_flag=1, LOADI r5=8'h81, then ROR-style op 1011 r6=r5:
  - r6=8'hC0;
  - carry_flag stays 1 (non-arith op).
- EQ r7=r3,r3 gives 8'h01. Then LOADI r3=8'h11 followed by EQ r7=r3,r1 gives 8'h00, with the second instruction accepted exactly 3 cycles after the first.
- Hold in_valid high continuously with 4 instructions queued: in_ready pattern is 1,0,0,1,0,0…; exactly 4 done pulses; no instruction dropped or duplicated.
- Assert rst during EXEC of ADD r1=r1+r1:
  - no done pulse;
  - all registers read 0;
  - carry_flag=0;
  - in_ready=1 on the cycle after rst deasserts.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM states, widths.
package alu_pkg;

  localparam int ALU_DW   = 8;
  localparam int ALU_NREG = 8;
  localparam int ALU_AW   = $clog2(ALU_NREG);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOT   = 4'b0101;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SHR   = 4'b0111;
  localparam logic [3:0] OP_INC   = 4'b1000;
  localparam logic [3:0] OP_DEC   = 4'b1001;
  localparam logic [3:0] OP_ROL   = 4'b1010;
  localparam logic [3:0] OP_ROR   = 4'b1011;
  localparam logic [3:0] OP_EQ    = 4'b1100;
  localparam logic [3:0] OP_RSV0  = 4'b1101;
  localparam logic [3:0] OP_RSV1  = 4'b1110;
  localparam logic [3:0] OP_LOADI = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    WB   = ST_WB
  } state_e;

  // Only ADD and SUB produce an architectural carry.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction channel: valid/ready handshake from the instruction source.
interface alu_issue_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 3
) ();
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic [DW-1:0] in_imm;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// Architectural register file: one synchronous write port, two operand reads
// and a debug read, all combinational. Reset clears every entry.
module alu_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] dbg_ra,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic [DW-1:0] dbg_rd
);
  logic [NREG-1:0][DW-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (rst)
      r_mem <= '0;
    else if (we)
      r_mem[waddr] <= wdata;
  end

  // Reads see the old value during a write cycle.
  assign rd1    = r_mem[ra1];
  assign rd2    = r_mem[ra2];
  assign dbg_rd = r_mem[dbg_ra];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external combinational ALU: accept, execute,
// write back. One instruction every three cycles, no forwarding needed.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW   = ALU_DW,
  parameter int NREG = ALU_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave ifc,
  output logic [3:0]      alu_ctrl,
  output logic [DW-1:0]   alu_x,
  output logic [DW-1:0]   alu_y,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_carry,
  output logic            done,
  output logic [DW-1:0]   done_data,
  output logic            carry_flag,
  input  logic [AW-1:0]   dbg_addr,
  output logic [DW-1:0]   dbg_data
);
  state_e        r_state;
  logic [3:0]    r_ctrl;
  logic [DW-1:0] r_x;
  logic [DW-1:0] r_y;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_result;
  logic          r_carry_cap;
  logic          r_carry;
  logic          r_done;

  logic [DW-1:0] w_rs1_data;
  logic [DW-1:0] w_rs2_data;
  logic [DW-1:0] w_result;
  logic          w_accept;
  logic          w_wb;

  assign w_accept = (r_state == IDLE) && ifc.in_valid;
  assign w_wb     = (r_state == WB);

  alu_regfile #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (w_wb),
    .waddr  (r_rd),
    .wdata  (r_result),
    .ra1    (ifc.in_rs1),
    .ra2    (ifc.in_rs2),
    .dbg_ra (dbg_addr),
    .rd1    (w_rs1_data),
    .rd2    (w_rs2_data),
    .dbg_rd (dbg_data)
  );

  // LOADI bypasses the ALU; reserved ops always write zero.
  always_comb begin
    w_result = alu_out;
    if (r_ctrl == OP_LOADI)
      w_result = r_imm;
    else if ((r_ctrl == OP_RSV0) || (r_ctrl == OP_RSV1))
      w_result = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ctrl      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_result    <= '0;
      r_carry_cap <= 1'b0;
      r_carry     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ctrl  <= ifc.in_op;
            r_x     <= w_rs1_data;
            r_y     <= w_rs2_data;
            r_rd    <= ifc.in_rd;
            r_imm   <= ifc.in_imm;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result    <= w_result;
          r_carry_cap <= alu_carry;
          r_done      <= 1'b1;
          r_state     <= WB;
        end
        WB: begin
          if (is_arith(r_ctrl))
            r_carry <= r_carry_cap;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ifc.in_ready = (r_state == IDLE);
  assign alu_ctrl     = r_ctrl;
  assign alu_x        = r_x;
  assign alu_y        = r_y;
  assign done         = r_done;
  assign done_data    = r_result;
  assign carry_flag   = r_carry;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU on the bus.
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x, alu_y, alu_out;
  logic       alu_carry;
  logic       done, carry_flag;
  logic [7:0] done_data, dbg_data;
  logic [2:0] dbg_addr = 3'd0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs = 0;

  alu_issue_ctrl_if #(.DW(8), .AW(3)) ifc ();

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .ifc(ifc),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .done(done), .done_data(done_data), .carry_flag(carry_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU; non-arith ops drive carry 0, reserved ops drive junk.
  always_comb begin
    alu_out   = alu_x ^ alu_y;
    alu_carry = 1'b0;
    case (alu_ctrl)
      4'b0000: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      4'b0001: {alu_carry, alu_out} = {1'b0, alu_x} - {1'b0, alu_y};
      4'b1011: alu_out = {alu_x[0], alu_x[7:1]};
      4'b1100: alu_out = (alu_x == alu_y) ? 8'h01 : 8'h00;
      4'b1101, 4'b1110: begin alu_out = 8'hAA; alu_carry = 1'b1; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rdreg(input logic [2:0] a, input logic [7:0] exp, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [7:0] imm);
    ifc.in_op = op; ifc.in_rd = rd; ifc.in_rs1 = rs1; ifc.in_rs2 = rs2; ifc.in_imm = imm;
  endtask

  // Issue one instruction; checks EXEC bus values and the done pulse at N+2.
  task automatic run(input string tag, input logic [3:0] op, input logic [2:0] rd,
                     input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm,
                     input logic [7:0] ex, input logic [7:0] ey, input logic [7:0] eres);
    int n;
    @(negedge clk);
    set_instr(op, rd, rs1, rs2, imm);
    ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 10) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, {31'd0, ifc.in_ready}, 32'd1);
    @(posedge clk); #1;
    last_hs = cyc;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_exec_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_exec_rdy"}, {31'd0, ifc.in_ready}, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, op});
    chk({tag, "_x"}, {24'd0, alu_x}, {24'd0, ex});
    chk({tag, "_y"}, {24'd0, alu_y}, {24'd0, ey});
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_data"}, {24'd0, done_data}, {24'd0, eres});
  endtask

  logic [7:0] exp_stream [4] = '{8'h11, 8'h22, 8'h33, 8'h66};

  initial begin
    int hs0, idx, ndone, hs;
    ifc.in_valid = 1'b0;
    set_instr(4'd0, 3'd0, 3'd0, 3'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_rdy", {31'd0, ifc.in_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {24'd0, done_data}, 32'd0);
    chk("rst_carry", {31'd0, carry_flag}, 32'd0);
    chk("rst_bus", {20'd0, alu_ctrl, alu_x}, 32'd0);

    run("ldi_r1", 4'hF, 3'd1, 3'd0, 3'd0, 8'hF0, 8'h00, 8'h00, 8'hF0);
    run("ldi_r2", 4'hF, 3'd2, 3'd0, 3'd0, 8'h20, 8'h00, 8'h00, 8'h20);
    run("add_r3", 4'h0, 3'd3, 3'd1, 3'd2, 8'h00, 8'hF0, 8'h20, 8'h10);
    @(negedge clk);
    chk("add_carry", {31'd0, carry_flag}, 32'd1);
    rdreg(3'd3, 8'h10, "dbg_r3");

    run("sub_r4", 4'h1, 3'd4, 3'd2, 3'd1, 8'h00, 8'h20, 8'hF0, 8'h30);
    @(negedge clk);
    chk("sub_carry", {31'd0, carry_flag}, 32'd1);
    rdreg(3'd4, 8'h30, "dbg_r4");

    run("ldi_r5", 4'hF, 3'd5, 3'd0, 3'd0, 8'h81, 8'h00, 8'h00, 8'h81);
    run("ror_r6", 4'hB, 3'd6, 3'd5, 3'd5, 8'h00, 8'h81, 8'h81, 8'hC0);
    @(negedge clk);
    chk("ror_carry", {31'd0, carry_flag}, 32'd1);
    rdreg(3'd6, 8'hC0, "dbg_r6");

    run("eq_same", 4'hC, 3'd7, 3'd3, 3'd3, 8'h00, 8'h10, 8'h10, 8'h01);
    run("ldi_r3", 4'hF, 3'd3, 3'd0, 3'd0, 8'h11, 8'h00, 8'h00, 8'h11);
    hs0 = last_hs;
    run("eq_diff", 4'hC, 3'd7, 3'd3, 3'd1, 8'h00, 8'h11, 8'hF0, 8'h00);
    chk("b2b_gap", last_hs - hs0, 32'd3);

    run("rsv_r5", 4'hD, 3'd5, 3'd1, 3'd2, 8'h00, 8'hF0, 8'h20, 8'h00);
    @(negedge clk);
    chk("rsv_carry", {31'd0, carry_flag}, 32'd1);
    rdreg(3'd5, 8'h00, "dbg_r5");

    // Streaming: in_valid held high, four queued instructions.
    @(posedge clk); #1;
    idx = 0; ndone = 0;
    set_instr(4'hF, 3'd1, 3'd0, 3'd0, 8'h11);
    ifc.in_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 9) chk($sformatf("strm_rdy%0d", c), {31'd0, ifc.in_ready}, {31'd0, (c % 3) == 0});
      if (done) begin
        if (ndone < 4) chk($sformatf("strm_data%0d", ndone), {24'd0, done_data}, {24'd0, exp_stream[ndone]});
        ndone++;
      end
      hs = int'(ifc.in_ready && ifc.in_valid);
      @(posedge clk); #1;
      if (hs != 0) begin
        idx++;
        case (idx)
          1: set_instr(4'hF, 3'd2, 3'd0, 3'd0, 8'h22);
          2: set_instr(4'h0, 3'd3, 3'd1, 3'd2, 8'h00);
          3: set_instr(4'h0, 3'd4, 3'd3, 3'd3, 8'h00);
          default: ifc.in_valid = 1'b0;
        endcase
      end
    end
    chk("strm_ndone", ndone, 32'd4);
    chk("strm_carry", {31'd0, carry_flag}, 32'd0);
    rdreg(3'd4, 8'h66, "dbg_strm_r4");

    run("ldi_r1b", 4'hF, 3'd1, 3'd0, 3'd0, 8'h80, 8'h00, 8'h00, 8'h80);
    run("add_r2b", 4'h0, 3'd2, 3'd1, 3'd1, 8'h00, 8'h80, 8'h80, 8'h00);
    @(negedge clk);
    chk("pre_rst_carry", {31'd0, carry_flag}, 32'd1);

    // Reset in EXEC of ADD r1=r1+r1: no writeback, no done.
    set_instr(4'h0, 3'd1, 3'd1, 3'd1, 8'h00);
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_exec", {31'd0, ifc.in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rdy", {31'd0, ifc.in_ready}, 32'd1);
    chk("abort_carry", {31'd0, carry_flag}, 32'd0);
    @(negedge clk);
    chk("abort_done2", {31'd0, done}, 32'd0);
    for (int r = 0; r < 8; r++) rdreg(r[2:0], 8'h00, $sformatf("abort_r%0d", r));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
